// File: rtl/conv_window_loader.sv
// rtl/conv_window_loader.sv - K x K window buffer load sequencer for one convolution layer
// Build option WINDOW_SHIFT_EN: horizontal slides shift the buffer and fetch only STRIDE new columns.
module conv_window_loader #(
  parameter int PIC_W  = 8,
  parameter int PIC_H  = 8,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 8,
  localparam int BW    = (K > 1) ? $clog2(K) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              initLd,
  input  logic              ldBuf,
  output logic              memRdEn,
  output logic [ADDR_W-1:0] memAddr,
  output logic              bufWrEn,
  output logic [BW-1:0]     bufRow,
  output logic [BW-1:0]     bufCol,
  output logic              bufShift,
  output logic              ldBufDone,
  output logic              ctrlDone
);

  localparam int RW       = (PIC_H > 1) ? $clog2(PIC_H) : 1;
  localparam int CW       = (PIC_W > 1) ? $clog2(PIC_W) : 1;
  localparam int LAST_ROW = PIC_H - K;
  localparam int LAST_COL = PIC_W - K;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD_FULL = 3'd1;
`ifdef WINDOW_SHIFT_EN
  localparam logic [2:0] LOAD_COLS = 3'd2;
  localparam logic [BW-1:0] C_NEW0 = BW'(K - STRIDE);
`endif
  localparam logic [2:0] FLUSH     = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  localparam logic [BW-1:0] C_LAST = BW'(K - 1);

  logic [2:0]    r_state;
  logic [RW-1:0] r_win_row;
  logic [CW-1:0] r_win_col;
  logic [BW-1:0] r_rd_r;
  logic [BW-1:0] r_rd_c;
  logic          r_wr_en;
  logic [BW-1:0] r_wr_row;
  logic [BW-1:0] r_wr_col;
  logic          r_ctrl_done;

  logic              w_rd_en;
  logic              w_col_fits;
  logic              w_last_win;
  logic [ADDR_W-1:0] w_addr;

`ifdef WINDOW_SHIFT_EN
  assign w_rd_en = (r_state == LOAD_FULL) || (r_state == LOAD_COLS);
`else
  assign w_rd_en = (r_state == LOAD_FULL);
`endif

  assign w_col_fits = (int'(r_win_col) + STRIDE) <= LAST_COL;
  assign w_last_win = (int'(r_win_row) == LAST_ROW) && (int'(r_win_col) == LAST_COL);
  assign w_addr     = ADDR_W'((int'(r_win_row) + int'(r_rd_r)) * PIC_W
                              + int'(r_win_col) + int'(r_rd_c));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_win_row   <= '0;
      r_win_col   <= '0;
      r_rd_r      <= '0;
      r_rd_c      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_row    <= '0;
      r_wr_col    <= '0;
      r_ctrl_done <= 1'b0;
    end else begin
      // Read data returns one cycle later, so the write side trails the read side by one stage.
      r_wr_en <= w_rd_en;
      if (w_rd_en) begin
        r_wr_row <= r_rd_r;
        r_wr_col <= r_rd_c;
      end

      case (r_state)
        // DONE takes commands too, so the controller can respond to ldBufDone at once.
        IDLE, DONE: begin
          if (initLd) begin
            r_win_row   <= '0;
            r_win_col   <= '0;
            r_rd_r      <= '0;
            r_rd_c      <= '0;
            r_ctrl_done <= 1'b0;
            r_state     <= LOAD_FULL;
          end else if (ldBuf && !r_ctrl_done) begin
            r_rd_r <= '0;
            if (w_col_fits) begin
              r_win_col <= CW'(int'(r_win_col) + STRIDE);
`ifdef WINDOW_SHIFT_EN
              r_rd_c    <= C_NEW0;
              r_state   <= LOAD_COLS;
`else
              r_rd_c    <= '0;
              r_state   <= LOAD_FULL;
`endif
            end else begin
              r_win_col <= '0;
              r_win_row <= RW'(int'(r_win_row) + STRIDE);
              r_rd_c    <= '0;
              r_state   <= LOAD_FULL;
            end
          end else begin
            r_state <= IDLE;
          end
        end

        LOAD_FULL: begin
          if (r_rd_c == C_LAST) begin
            r_rd_c <= '0;
            if (r_rd_r == C_LAST) begin
              r_rd_r  <= '0;
              r_state <= FLUSH;
            end else begin
              r_rd_r <= r_rd_r + BW'(1);
            end
          end else begin
            r_rd_c <= r_rd_c + BW'(1);
          end
        end

`ifdef WINDOW_SHIFT_EN
        LOAD_COLS: begin
          if (r_rd_c == C_LAST) begin
            r_rd_c <= C_NEW0;
            if (r_rd_r == C_LAST) begin
              r_rd_r  <= '0;
              r_state <= FLUSH;
            end else begin
              r_rd_r <= r_rd_r + BW'(1);
            end
          end else begin
            r_rd_c <= r_rd_c + BW'(1);
          end
        end
`endif

        FLUSH: begin
          r_ctrl_done <= w_last_win;
          r_state     <= DONE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign memRdEn   = w_rd_en;
  assign memAddr   = w_rd_en ? w_addr : '0;
  assign bufWrEn   = r_wr_en;
  assign bufRow    = r_wr_row;
  assign bufCol    = r_wr_col;
  assign ldBufDone = (r_state == DONE);
  assign ctrlDone  = r_ctrl_done;

`ifdef WINDOW_SHIFT_EN
  assign bufShift = (r_state == LOAD_COLS) && (r_rd_r == '0) && (r_rd_c == C_NEW0);
`else
  assign bufShift = 1'b0;
`endif

endmodule

// File: tb/tb_conv_window_loader.sv
// tb/tb_conv_window_loader.sv - directed bench for conv_window_loader on a 6x5 picture, K=3, STRIDE=1
module tb_conv_window_loader;

  localparam int PW = 6;
  localparam int PH = 5;
  localparam int KK = 3;
  localparam int ST = 1;
`ifdef WINDOW_SHIFT_EN
  localparam bit SHIFT = 1'b1;
`else
  localparam bit SHIFT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       initLd = 1'b0;
  logic       ldBuf = 1'b0;
  logic       memRdEn;
  logic [7:0] memAddr;
  logic       bufWrEn;
  logic [1:0] bufRow;
  logic [1:0] bufCol;
  logic       bufShift;
  logic       ldBufDone;
  logic       ctrlDone;

  conv_window_loader #(
    .PIC_W(PW), .PIC_H(PH), .K(KK), .STRIDE(ST), .ADDR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .initLd(initLd), .ldBuf(ldBuf),
    .memRdEn(memRdEn), .memAddr(memAddr), .bufWrEn(bufWrEn),
    .bufRow(bufRow), .bufCol(bufCol), .bufShift(bufShift),
    .ldBufDone(ldBufDone), .ctrlDone(ctrlDone)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int q_addr[$];
  int q_rc[$];
  int rd_first, wr_first, wr_cnt, shift_cnt, shift_cyc, done_cyc, cd_at_done, cd_c1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_list(input string tag, input int obs[$], input int exp[$]);
    chk({tag, "_len"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), obs[i], exp[i]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_memRdEn"},   int'(memRdEn),   0);
    chk({tag, "_memAddr"},   int'(memAddr),   0);
    chk({tag, "_bufWrEn"},   int'(bufWrEn),   0);
    chk({tag, "_bufRow"},    int'(bufRow),    0);
    chk({tag, "_bufCol"},    int'(bufCol),    0);
    chk({tag, "_bufShift"},  int'(bufShift),  0);
    chk({tag, "_ldBufDone"}, int'(ldBufDone), 0);
    chk({tag, "_ctrlDone"},  int'(ctrlDone),  0);
  endtask

  // Cycle k is the k-th cycle after the command edge; sampling happens at its falling edge.
  task automatic run_cmd(input logic c_init, input logic c_ld, input int max_cyc, input int inject_cyc);
    q_addr.delete();
    q_rc.delete();
    rd_first = -1; wr_first = -1; wr_cnt = 0; shift_cnt = 0; shift_cyc = -1;
    done_cyc = -1; cd_at_done = -1; cd_c1 = -1;
    @(negedge clk);
    initLd = c_init;
    ldBuf  = c_ld;
    @(negedge clk);
    initLd = 1'b0;
    ldBuf  = 1'b0;
    for (int k = 1; k <= max_cyc; k++) begin
      ldBuf = (inject_cyc > 0) && (k == inject_cyc);
      if (k == 1) cd_c1 = int'(ctrlDone);
      if (memRdEn) begin
        q_addr.push_back(int'(memAddr));
        if (rd_first < 0) rd_first = k;
      end
      if (bufWrEn) begin
        q_rc.push_back(int'(bufRow) * 3 + int'(bufCol));
        if (wr_first < 0) wr_first = k;
        wr_cnt++;
      end
      if (bufShift) begin
        shift_cnt++;
        if (shift_cyc < 0) shift_cyc = k;
      end
      if (ldBufDone && done_cyc < 0) begin
        done_cyc   = k;
        cd_at_done = int'(ctrlDone);
      end
      if (done_cyc > 0) break;
      @(negedge clk);
    end
    ldBuf = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int row;
    int col;
    int exp_first;
    int exp_n;
    int act_cnt;
    bit full;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // first window at origin (0,0)
    run_cmd(1'b1, 1'b0, 30, 0);
    chk_list("init_addr", q_addr, '{0, 1, 2, 6, 7, 8, 12, 13, 14});
    chk("init_rd_first", rd_first, 1);
    chk("init_wr_first", wr_first, 2);
    chk("init_wr_cnt", wr_cnt, 9);
    chk_list("init_rc", q_rc, '{0, 1, 2, 3, 4, 5, 6, 7, 8});
    chk("init_shift_cnt", shift_cnt, 0);
    chk("init_done_cyc", done_cyc, 11);
    chk("init_ctrldone", cd_at_done, 0);

    // slide to (0,1)
    run_cmd(1'b0, 1'b1, 30, 0);
    if (SHIFT) begin
      chk_list("slide_addr", q_addr, '{3, 9, 15});
      chk("slide_shift_cyc", shift_cyc, 1);
      chk("slide_shift_cnt", shift_cnt, 1);
      chk_list("slide_rc", q_rc, '{2, 5, 8});
      chk("slide_wr_first", wr_first, 2);
      chk("slide_done_cyc", done_cyc, 5);
    end else begin
      chk_list("slide_addr", q_addr, '{1, 2, 3, 7, 8, 9, 13, 14, 15});
      chk("slide_shift_cnt", shift_cnt, 0);
      chk_list("slide_rc", q_rc, '{0, 1, 2, 3, 4, 5, 6, 7, 8});
      chk("slide_done_cyc", done_cyc, 11);
    end

    // (0,2) and (0,3)
    run_cmd(1'b0, 1'b1, 30, 0);
    run_cmd(1'b0, 1'b1, 30, 0);
    chk("w4_first", (q_addr.size() > 0) ? q_addr[0] : -1, SHIFT ? 5 : 3);
    chk("w4_done_cyc", done_cyc, SHIFT ? 5 : 11);

    // row wrap to (1,0)
    run_cmd(1'b0, 1'b1, 30, 0);
    chk_list("wrap_addr", q_addr, '{6, 7, 8, 12, 13, 14, 18, 19, 20});
    chk("wrap_shift_cnt", shift_cnt, 0);
    chk("wrap_done_cyc", done_cyc, 11);
    chk("wrap_ctrldone", cd_at_done, 0);

    // windows 6..12
    row = 1;
    col = 0;
    for (int w = 6; w <= 12; w++) begin
      col++;
      if (col > PW - KK) begin
        col = 0;
        row++;
      end
      run_cmd(1'b0, 1'b1, 30, 0);
      full      = (col == 0) || !SHIFT;
      exp_first = row * PW + col + (full ? 0 : KK - ST);
      exp_n     = full ? KK * KK : KK * ST;
      chk($sformatf("w%0d_first", w), (q_addr.size() > 0) ? q_addr[0] : -1, exp_first);
      chk($sformatf("w%0d_nreads", w), q_addr.size(), exp_n);
      chk($sformatf("w%0d_ctrldone", w), cd_at_done, (w == 12) ? 1 : 0);
    end
    chk("last_addr", (q_addr.size() > 0) ? q_addr[q_addr.size() - 1] : -1, 4 * PW + 5);

    // past the last window
    run_cmd(1'b0, 1'b1, 15, 0);
    chk("past_nreads", q_addr.size(), 0);
    chk("past_done", done_cyc, -1);
    chk("past_ctrldone", int'(ctrlDone), 1);

    // restart clears ctrlDone
    run_cmd(1'b1, 1'b0, 30, 0);
    chk("restart_cd_c1", cd_c1, 0);
    chk("restart_first", (q_addr.size() > 0) ? q_addr[0] : -1, 0);
    chk("restart_nreads", q_addr.size(), 9);
    chk("restart_done_cyc", done_cyc, 11);

    // reset in cycle 5 of a full load
    @(negedge clk);
    initLd = 1'b1;
    @(negedge clk);
    initLd = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    act_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bufWrEn || ldBufDone || memRdEn) act_cnt++;
    end
    chk("postrst_activity", act_cnt, 0);

    // both commands, plus a ldBuf injected mid-load
    run_cmd(1'b1, 1'b1, 30, 4);
    chk_list("both_addr", q_addr, '{0, 1, 2, 6, 7, 8, 12, 13, 14});
    chk("both_shift_cnt", shift_cnt, 0);
    chk("both_done_cyc", done_cyc, 11);
    act_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (memRdEn) act_cnt++;
    end
    chk("both_idle_after", act_cnt, 0);

    // origin must still be (0,0), so the next slide lands on (0,1)
    run_cmd(1'b0, 1'b1, 30, 0);
    chk("after_both_first", (q_addr.size() > 0) ? q_addr[0] : -1, SHIFT ? 3 : 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_loader.md
# conv_window_loader

Sequencer that fills a convolution layer's K×K window buffer from its input picture memory. It is commanded by the layer controller (`initLd` / `ldBuf`) and answers with `ldBufDone` and `ctrlDone`. It walks the window origin across the picture in raster order with a programmable stride, generating memory read addresses and buffer write strobes. One instance is used per layer (L1, L2).

## Interface
Parameters:
- `PIC_W`, 8: picture width in words.
- `PIC_H`, 8: picture height in words.
- `K`, 3: window size. Constraint: K ≤ PIC_W and K ≤ PIC_H.
- `STRIDE`, 1: origin step, horizontal and vertical. Constraints: (PIC_W−K) % STRIDE == 0, (PIC_H−K) % STRIDE == 0, STRIDE ≤ K.
- `ADDR_W`, 8: memory address width.

Ports:
- `clk` input 1: the single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `initLd` input 1: one-cycle pulse; restart at origin (0,0) and full-load the window.
- `ldBuf` input 1: one-cycle pulse; advance to the next window and load it.
- `memRdEn` output 1: picture memory read enable.
- `memAddr` output ADDR_W: read address = (winRow+r)*PIC_W + (winCol+c), truncated to ADDR_W.
- `bufWrEn` output 1: window buffer write strobe for the returning data.
- `bufRow` output clog2(K): buffer row of the current write.
- `bufCol` output clog2(K): buffer column of the current write.
- `bufShift` output 1: one-cycle pulse; buffer shifts its contents left by STRIDE columns.
- `ldBufDone` output 1: one-cycle pulse when the window load completes.
- `ctrlDone` output 1: level; the current window is the last one, with origin (PIC_H−K, PIC_W−K).

## Operation
- States: IDLE, LOAD_FULL, LOAD_COLS, FLUSH, DONE.
- IDLE behaviour:
  - `initLd`: set origin to (0,0), clear `ctrlDone`, go to LOAD_FULL.
  - `ldBuf` with `ctrlDone`=0 and winCol+STRIDE ≤ PIC_W−K: set winCol += STRIDE, go to LOAD_COLS.
  - `ldBuf` with `ctrlDone`=0, otherwise: set winCol=0, winRow += STRIDE, go to LOAD_FULL.
  - `ldBuf` while `ctrlDone`=1: ignored, no reads issued.
- LOAD_FULL: issue K*K reads in row-major order (r outer, c inner), r,c ∈ [0,K).
- LOAD_COLS: pulse `bufShift` in its first cycle, then issue K*STRIDE reads in row-major order, r ∈ [0,K), c ∈ [K−STRIDE, K).
- After the last read: go to FLUSH for one cycle, during which the final write occurs.
- DONE: pulse `ldBufDone` for one cycle, update `ctrlDone`, return to IDLE.
- Memory read latency is 1 cycle. `bufWrEn`, `bufRow` and `bufCol` are the read-side `memRdEn`, r and c delayed by one register stage.
- `initLd` and `ldBuf` in the same cycle: `initLd` wins.
- Commands outside IDLE are ignored.
- Reset asserted mid-load: all outputs go to 0 immediately and state goes to IDLE. In-flight read data is discarded; no `bufWrEn` follows reset release.

## Timing
- Reset values:
  - `memRdEn`, `bufWrEn`, `bufShift`, `ldBufDone`, `ctrlDone` = 0.
  - `memAddr`, `bufRow`, `bufCol` = 0.
  - State = IDLE; origin = (0,0).
- Command sampled at edge E0. Reads occur in cycles 1..N after E0:
  - N = K*K for a full load.
  - N = K*STRIDE for a column load.
  - In a column load, `bufShift` is high in cycle 1, concurrent with the first read.
- `bufWrEn` is high in cycles 2..N+1.
- `ldBufDone` is high in cycle N+2.
- `ctrlDone` changes in the same cycle `ldBufDone` pulses and holds until the next `initLd` or reset.
- The earliest accepted next command is sampled at the edge ending cycle N+2.

## Configuration
- Macro `WINDOW_SHIFT_EN`.
- Defined: horizontal slides use LOAD_COLS (shift plus K*STRIDE reads) as described.
- Undefined: LOAD_COLS is not built.
  - Every `ldBuf` performs LOAD_FULL at the new origin (K*K reads).
  - `bufShift` is tied to 0.
  - Origin sequencing and `ctrlDone` behaviour are unchanged.

## Test plan
All scenarios use PIC_W=6, PIC_H=5, K=3, STRIDE=1.
- Reset, then `initLd` → addresses 0,1,2,6,7,8,12,13,14; `bufWrEn` in cycles 2..10; (bufRow,bufCol) (0,0)…(2,2); `ldBufDone` in cycle 11; `ctrlDone`=0.
- `ldBuf` after first window, macro defined → `bufShift` in cycle 1; addresses 3,9,15; `ldBufDone` in cycle 5. Macro undefined → addresses 1,2,3,7,8,9,13,14,15; `ldBufDone` in cycle 11.
- Advance to origin (0,3), then `ldBuf` → full load at (1,0): addresses 6,7,8,12,13,14,18,19,20.
- Step through all 12 windows → `ctrlDone` rises with the 12th `ldBufDone`. A further `ldBuf` produces no `memRdEn`. `initLd` clears `ctrlDone` and reloads from address 0.
- Assert `rst` low in cycle 5 of a full load → all outputs 0 that cycle. After release, no `bufWrEn`/`ldBufDone` without a new command.
- `initLd` and `ldBuf` together; `ldBuf` during a load → origin (0,0) full load only; mid-load command ignored, address sequence unchanged.
